// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and the key-map lookup for the
// keypad scanner slice.
//   key_t        : 4-bit key code (0-9, A='*', B='#', F=no key)
//   scan_state_t : DRIVE/SAMPLE states of the row scan
//   key_code()   : row/column position to key code
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 3;

    typedef logic [3:0] key_t;

    localparam key_t KEY_NONE = 4'hF;
    localparam key_t KEY_STAR = 4'hA;
    localparam key_t KEY_HASH = 4'hB;

    typedef enum logic {
        ST_DRIVE,
        ST_SAMPLE
    } scan_state_t;

    // Layout, rows top to bottom: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
    function automatic key_t key_code(input int unsigned row, input int unsigned col);
        key_t code;
        if (row < ROWS - 1) begin
            code = key_t'(row * COLS + col + 1);
        end else begin
            case (col)
                0:       code = KEY_STAR;
                1:       code = 4'h0;
                default: code = KEY_HASH;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix and key-report signals.
//   row_n     : row drive, active-low, one row low at a time
//   col_n     : column sense, active-low, asynchronous to clk
//   key       : accepted key code (F = no key)
//   key_valid : one-cycle strobe on a newly accepted key
//   key_held  : high while an accepted key is pressed
// slave = scanner side, master = keypad / consumer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    key_t            key;
    logic            key_valid;
    logic            key_held;

    modport slave (
        output row_n,
        input  col_n,
        output key,
        output key_valid,
        output key_held
    );

    modport master (
        input  row_n,
        output col_n,
        input  key,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce of scan results.
//   clk, reset : clock, asynchronous active-high reset
//   frame_stb  : one cycle per completed scan frame
//   frame_code : key code seen in that frame (F = none / ambiguous)
//   key        : accepted key code
//   key_valid  : one-cycle pulse when a new non-F code is accepted
//   key_held   : accepted code is a real key
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_stb,
    input  key_t frame_code,
    output key_t key,
    output logic key_valid,
    output logic key_held
);

    key_t       candidate;
    key_t       cand_next;
    key_t       accepted;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       accept;

    always_comb begin
        cand_next  = candidate;
        count_next = count;
        if (frame_code == candidate) begin
            count_next = (count == 4'(DEBOUNCE)) ? count : count + 4'd1;
        end else begin
            cand_next  = frame_code;
            count_next = 4'd1;
        end
        accept = (count_next == 4'(DEBOUNCE)) && (cand_next != accepted);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= KEY_NONE;
            count     <= '0;
            accepted  <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_stb) begin
                candidate <= cand_next;
                count     <= count_next;
                if (accept) begin
                    accepted  <= cand_next;
                    // Strobe shares the edge that updates accepted, so it
                    // lines up with the first cycle key shows the new code.
                    key_valid <= (cand_next != KEY_NONE);
                    key_held  <= (cand_next != KEY_NONE);
                end
            end
        end
    end

    assign key = accepted;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 active-low keypad scanner with column synchroniser,
// row-scan FSM and frame-level debounce.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : keypad_scanner_if.slave (row_n, col_n, key, key_valid, key_held)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.slave   bus
);

    localparam int unsigned SAMPLE_PT = SCAN_DIV - 1;
    localparam int unsigned DW        = $clog2(SCAN_DIV);

    logic [COLS-1:0]             col_s1;
    logic [COLS-1:0]             col_s2;
    scan_state_t                 state;
    logic [DW-1:0]               dwell;
    logic [1:0]                  row_idx;
    logic [ROWS-1:0]             row_n_q;
    logic [ROWS-2:0][COLS-1:0]   rows_q;

    logic                        frame_stb;
    logic [ROWS-1:0][COLS-1:0]   frame_cols;
    logic [3:0]                  hits;
    key_t                        hit_code;
    key_t                        frame_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_s1  <= '1;
            col_s2  <= '1;
            state   <= ST_DRIVE;
            dwell   <= '0;
            row_idx <= '0;
            row_n_q <= 4'b1110;
            rows_q  <= '1;
        end else begin
            col_s1 <= bus.col_n;
            col_s2 <= col_s1;
            case (state)
                ST_DRIVE: begin
                    if (dwell == DW'(SAMPLE_PT - 1)) begin
                        dwell <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // The last row is not stored: it is consumed directly
                    // from col_s2 by the frame evaluation in this cycle.
                    case (row_idx)
                        2'd0:    rows_q[0] <= col_s2;
                        2'd1:    rows_q[1] <= col_s2;
                        2'd2:    rows_q[2] <= col_s2;
                        default: ;
                    endcase
                    row_idx <= row_idx + 1'b1;
                    row_n_q <= {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
                    state   <= ST_DRIVE;
                end
                default: state <= ST_DRIVE;
            endcase
        end
    end

    assign frame_stb  = (state == ST_SAMPLE) && (row_idx == 2'(ROWS - 1));
    assign frame_cols = {col_s2, rows_q};

    // Exactly one pressed contact yields a code; none or several give F.
    always_comb begin
        hits     = '0;
        hit_code = KEY_NONE;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (!frame_cols[r][c]) begin
                    hits     = hits + 4'd1;
                    hit_code = key_code(r, c);
                end
            end
        end
        frame_code = (hits == 4'd1) ? hit_code : KEY_NONE;
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame_stb  (frame_stb),
        .frame_code (frame_code),
        .key        (bus.key),
        .key_valid  (bus.key_valid),
        .key_held   (bus.key_held)
    );

    assign bus.row_n = row_n_q;

endmodule
